// File: rtl/spm_pkg.sv
// Register map of the serial-parallel multiplier and the state encoding
// shared by its Wishbone initiator.
package spm_pkg;

  localparam logic [31:0] X_OFF    = 32'h0000_0000;
  localparam logic [31:0] Y_OFF    = 32'h0000_0004;
  localparam logic [31:0] P_LO_OFF = 32'h0000_0008;
  localparam logic [31:0] P_HI_OFF = 32'h0000_000C;

  // The serial multiply needs this many cycles after the Y write before P is valid.
  localparam int MIN_WAIT_CYCLES = 66;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR_X  = 3'd1,
    ST_WR_Y  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RD_LO = 3'd4,
    ST_RD_HI = 3'd5
  } spm_state_e;

endpackage

// File: rtl/spm_wb_master_if.sv
// Wishbone classic bus between the multiplier initiator and the multiplier slave port.
interface spm_wb_master_if;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );

endinterface

// File: rtl/spm_wb_master.sv
// Wishbone classic initiator running one 32x32 job on the serial-parallel multiplier:
// write X, write Y, idle out the serial multiply, then read both product words.
module spm_wb_master
  import spm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          WAIT_CYCLES = 70,
  parameter int          TIMEOUT     = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            start_i,
  input  logic [31:0]     x_i,
  input  logic [31:0]     y_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [63:0]     product_o,
  spm_wb_master_if.master wbm
);

  localparam int WAIT_W = $clog2(WAIT_CYCLES);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [31:0] ADR_X    = BASE_ADDR + X_OFF;
  localparam logic [31:0] ADR_Y    = BASE_ADDR + Y_OFF;
  localparam logic [31:0] ADR_P_LO = BASE_ADDR + P_LO_OFF;
  localparam logic [31:0] ADR_P_HI = BASE_ADDR + P_HI_OFF;

  if (WAIT_CYCLES < MIN_WAIT_CYCLES) begin : g_wait_too_short
    $error("spm_wb_master: WAIT_CYCLES must be at least %0d", MIN_WAIT_CYCLES);
  end

  spm_state_e        state_reg;
  logic [31:0]       y_reg;
  logic [31:0]       p_lo_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [TMO_W-1:0]  tmo_cnt_reg;
  logic              req_reg;
  logic              we_reg;
  logic [31:0]       adr_reg;
  logic [31:0]       dat_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic [63:0]       product_reg;

  // cyc and stb always move together; sel is fully enabled for every request.
  assign wbm.wbm_cyc_o = req_reg;
  assign wbm.wbm_stb_o = req_reg;
  assign wbm.wbm_we_o  = we_reg;
  assign wbm.wbm_sel_o = {4{req_reg}};
  assign wbm.wbm_adr_o = adr_reg;
  assign wbm.wbm_dat_o = dat_reg;

  assign busy_o    = busy_reg;
  assign done_o    = done_reg;
  assign err_o     = err_reg;
  assign product_o = product_reg;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg    <= ST_IDLE;
      y_reg        <= '0;
      p_lo_reg     <= '0;
      wait_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      adr_reg      <= '0;
      dat_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      product_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          busy_reg <= 1'b0;
          if (start_i) begin
            busy_reg    <= 1'b1;
            y_reg       <= y_i;
            req_reg     <= 1'b1;
            we_reg      <= 1'b1;
            adr_reg     <= ADR_X;
            dat_reg     <= x_i;
            tmo_cnt_reg <= '0;
            state_reg   <= ST_WR_X;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_reg == '0) begin
            req_reg     <= 1'b1;
            we_reg      <= 1'b0;
            adr_reg     <= ADR_P_LO;
            tmo_cnt_reg <= '0;
            state_reg   <= ST_RD_LO;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        ST_WR_X, ST_WR_Y, ST_RD_LO, ST_RD_HI: begin
          // An ack on the same edge as the timeout limit still counts as success.
          if (wbm.wbm_ack_i) begin
            tmo_cnt_reg <= '0;
            case (state_reg)
              ST_WR_X: begin
                adr_reg   <= ADR_Y;
                dat_reg   <= y_reg;
                state_reg <= ST_WR_Y;
              end
              ST_WR_Y: begin
                req_reg      <= 1'b0;
                we_reg       <= 1'b0;
                dat_reg      <= '0;
                wait_cnt_reg <= WAIT_W'(WAIT_CYCLES - 1);
                state_reg    <= ST_WAIT;
              end
              ST_RD_LO: begin
                p_lo_reg  <= wbm.wbm_dat_i;
                adr_reg   <= ADR_P_HI;
                state_reg <= ST_RD_HI;
              end
              default: begin
                product_reg <= {wbm.wbm_dat_i, p_lo_reg};
                req_reg     <= 1'b0;
                done_reg    <= 1'b1;
                state_reg   <= ST_IDLE;
              end
            endcase
          end else if (tmo_cnt_reg == TMO_W'(TIMEOUT)) begin
            req_reg     <= 1'b0;
            we_reg      <= 1'b0;
            dat_reg     <= '0;
            tmo_cnt_reg <= '0;
            done_reg    <= 1'b1;
            err_reg     <= 1'b1;
            state_reg   <= ST_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        default: begin
          req_reg   <= 1'b0;
          we_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
